hazard_forward_unit: RTL and testbench

- Parametrised hazard-detection and forwarding unit for the in-order pipeline. It replaces the fixed 5-stage, 2-operand forwarding/hazard pair.
- Tracks every issued instruction's destination in a shadow pipe of DEPTH post-ID stages.
- Generates the ID stall, forwarding selects for operands consumed in ID (early branch compare) and in EX, and a stall-cycle performance counter.
- Generalises stage count, operand count, register-address width and result latency per instruction.

---
 rtl/hazard_forward_unit.sv | 115 +++++++++++
 tb/tb_hazard_forward_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - parametrised hazard detection and operand forwarding unit
// Shadow pipe of issued destinations drives the ID stall and per-operand ID/EX forwarding selects.
module hazard_forward_unit #(
  parameter int AW        = 5,
  parameter int DEPTH     = 4,
  parameter int NUM_SRC   = 2,
  parameter int SW        = 3,
  parameter int RF_BYPASS = 1,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_kill,
  input  logic                  id_wen,
  input  logic [AW-1:0]         id_dest,
  input  logic [SW-1:0]         id_rdy,
  input  logic [NUM_SRC*AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_use,
  input  logic [NUM_SRC-1:0]    id_src_early,
  output logic                  stall,
  output logic [NUM_SRC*SW-1:0] fwd_id_sel,
  output logic [NUM_SRC*SW-1:0] fwd_ex_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic                  valid_q [1:DEPTH];
  logic                  wen_q   [1:DEPTH];
  logic [AW-1:0]         dest_q  [1:DEPTH];
  logic [SW-1:0]         rdy_q   [1:DEPTH];
  logic [NUM_SRC*AW-1:0] src_q;
  logic [NUM_SRC-1:0]    use_q;
  logic [CNT_W-1:0]      stall_cnt_q;
  logic [CNT_W-1:0]      stall_cnt_d;
  logic                  issue_d;
  logic                  stall_raw;

  always_comb begin
    logic [SW-1:0] id_k;
    logic [SW-1:0] id_r;
    logic [SW-1:0] ex_k;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    stall_raw  = 1'b0;
    fwd_id_sel = '0;
    fwd_ex_sel = '0;
    id_k       = '0;
    id_r       = '0;
    ex_k       = '0;
    a          = '0;
    b          = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a    = id_src[i*AW +: AW];
      b    = src_q[i*AW +: AW];
      id_k = '0;
      id_r = '0;
      ex_k = '0;
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int k = DEPTH; k >= 1; k--) begin
        if (valid_q[k] && wen_q[k] && dest_q[k] == a && a != '0) begin
          id_k = SW'(k);
          id_r = rdy_q[k];
        end
      end
      for (int k = DEPTH; k >= 2; k--) begin
        if (valid_q[k] && wen_q[k] && dest_q[k] == b && b != '0) begin
          ex_k = SW'(k);
        end
      end
      if (id_src_use[i] && id_k != '0) begin
        if (id_src_early[i]) begin
          if (id_k > id_r) begin
            fwd_id_sel[i*SW +: SW] = (RF_BYPASS != 0 && id_k == SW'(DEPTH)) ? '0 : id_k;
          end else begin
            stall_raw = 1'b1;
          end
        end else if (id_k < id_r) begin
          stall_raw = 1'b1;
        end
      end
      if (valid_q[1] && use_q[i] && ex_k != '0) begin
        fwd_ex_sel[i*SW +: SW] = (RF_BYPASS != 0 && ex_k == SW'(DEPTH)) ? '0 : ex_k;
      end
    end
  end

  assign stall       = stall_raw & id_valid & ~id_kill;
  assign issue_d     = id_valid & ~id_kill & ~stall;
  assign stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        valid_q[k] <= 1'b0;
      end
      stall_cnt_q <= '0;
    end else begin
      valid_q[1] <= issue_d;
      wen_q[1]   <= id_wen;
      dest_q[1]  <= id_dest;
      rdy_q[1]   <= id_rdy;
      src_q      <= id_src;
      use_q      <= id_src_use;
      for (int k = 2; k <= DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        wen_q[k]   <= wen_q[k-1];
        dest_q[k]  <= dest_q[k-1];
        rdy_q[k]   <= rdy_q[k-1];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - randomized and directed bench for hazard_forward_unit
// Two instances (RF bypass on / off with a narrow counter) share stimulus and one reference model.
module tb_hazard_forward_unit;
  localparam int AW = 5;
  localparam int DEPTH = 4;
  localparam int NS = 2;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, id_kill, id_wen;
  logic [AW-1:0] id_dest;
  logic [SW-1:0] id_rdy;
  logic [NS*AW-1:0] id_src;
  logic [NS-1:0] id_src_use, id_src_early;
  logic a_stall, b_stall;
  logic [NS*SW-1:0] a_idsel, a_exsel, b_idsel, b_exsel;
  logic [31:0] a_cnt;
  logic [2:0] b_cnt;

  hazard_forward_unit #(.AW(AW), .DEPTH(DEPTH), .NUM_SRC(NS), .SW(SW), .RF_BYPASS(1), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill), .id_wen(id_wen),
    .id_dest(id_dest), .id_rdy(id_rdy), .id_src(id_src), .id_src_use(id_src_use),
    .id_src_early(id_src_early), .stall(a_stall), .fwd_id_sel(a_idsel),
    .fwd_ex_sel(a_exsel), .stall_cnt(a_cnt));

  hazard_forward_unit #(.AW(AW), .DEPTH(DEPTH), .NUM_SRC(NS), .SW(SW), .RF_BYPASS(0), .CNT_W(3)) u_nb (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill), .id_wen(id_wen),
    .id_dest(id_dest), .id_rdy(id_rdy), .id_src(id_src), .id_src_use(id_src_use),
    .id_src_early(id_src_early), .stall(b_stall), .fwd_id_sel(b_idsel),
    .fwd_ex_sel(b_exsel), .stall_cnt(b_cnt));

  typedef struct {
    bit v;
    bit w;
    int d;
    int r;
    int s[NS];
    bit u[NS];
  } instr_t;

  instr_t pipe[1:DEPTH];
  int cnt_a, cnt_b;
  int e_st;
  int e_id[2][NS];
  int e_ex[2][NS];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d want %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int ymatch(int a, int from);
    if (a == 0) return 0;
    for (int k = from; k <= DEPTH; k++)
      if (pipe[k].v && pipe[k].w && pipe[k].d == a) return k;
    return 0;
  endfunction

  function automatic int bypassed(int bp, int k);
    return (bp == 1 && k == DEPTH) ? 0 : k;
  endfunction

  function automatic void model_eval();
    int k, a;
    bit st;
    st = 0;
    for (int i = 0; i < NS; i++) begin
      a = int'(id_src[i*AW +: AW]);
      k = ymatch(a, 1);
      for (int bp = 0; bp < 2; bp++) begin
        e_id[bp][i] = 0;
        e_ex[bp][i] = 0;
      end
      if (id_src_use[i] && k != 0) begin
        if (id_src_early[i]) begin
          // Result exists at the end of stage rdy, so stage k's output register holds it once k > rdy.
          if (k > pipe[k].r) for (int bp = 0; bp < 2; bp++) e_id[bp][i] = bypassed(bp, k);
          else st = 1;
        end else if (k < pipe[k].r) begin
          st = 1;
        end
      end
      if (pipe[1].v && pipe[1].u[i]) begin
        k = ymatch(pipe[1].s[i], 2);
        for (int bp = 0; bp < 2; bp++) e_ex[bp][i] = bypassed(bp, k);
      end
    end
    e_st = (st && id_valid && !id_kill) ? 1 : 0;
  endfunction

  function automatic void model_update(bit r);
    if (r) begin
      for (int k = 1; k <= DEPTH; k++) pipe[k].v = 0;
      cnt_a = 0;
      cnt_b = 0;
      return;
    end
    if (e_st == 1) begin
      if (cnt_a != -1) cnt_a++;
      if (cnt_b < 7) cnt_b++;
    end
    for (int k = DEPTH; k >= 2; k--) pipe[k] = pipe[k-1];
    pipe[1].v = id_valid && !id_kill && e_st == 0;
    pipe[1].w = id_wen;
    pipe[1].d = int'(id_dest);
    pipe[1].r = int'(id_rdy);
    for (int i = 0; i < NS; i++) begin
      pipe[1].s[i] = int'(id_src[i*AW +: AW]);
      pipe[1].u[i] = id_src_use[i];
    end
  endfunction

  task automatic step(input bit r, input bit v, input bit kl, input bit w, input int d, input int rd,
                      input int s0, input int s1, input bit [1:0] u, input bit [1:0] e,
                      input int xs, input int xid, input int xex);
    @(negedge clk);
    rst = r; id_valid = v; id_kill = kl; id_wen = w;
    id_dest = AW'(d); id_rdy = SW'(rd);
    id_src = {AW'(s1), AW'(s0)};
    id_src_use = u; id_src_early = e;
    #1;
    model_eval();
    check("stall", {63'd0, a_stall}, 64'(e_st));
    check("stall_nb", {63'd0, b_stall}, 64'(e_st));
    for (int i = 0; i < NS; i++) begin
      check($sformatf("id_sel%0d", i), 64'(a_idsel[i*SW +: SW]), 64'(e_id[1][i]));
      check($sformatf("ex_sel%0d", i), 64'(a_exsel[i*SW +: SW]), 64'(e_ex[1][i]));
      check($sformatf("id_sel_nb%0d", i), 64'(b_idsel[i*SW +: SW]), 64'(e_id[0][i]));
      check($sformatf("ex_sel_nb%0d", i), 64'(b_exsel[i*SW +: SW]), 64'(e_ex[0][i]));
    end
    check("stall_cnt", 64'(a_cnt), 64'(unsigned'(cnt_a)));
    check("stall_cnt_nb", 64'(b_cnt), 64'(cnt_b));
    if (xs >= 0) check("plan_stall", {63'd0, a_stall}, 64'(xs));
    if (xid >= 0) check("plan_id_sel", 64'(a_idsel), 64'(xid));
    if (xex >= 0) check("plan_ex_sel", 64'(a_exsel), 64'(xex));
    @(posedge clk);
    model_update(r);
    cyc++;
  endtask

  task automatic nop(input int xex);
    step(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, -1, xex);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_kill = 0; id_wen = 0; id_dest = '0; id_rdy = '0;
    id_src = '0; id_src_use = '0; id_src_early = '0;
    for (int k = 1; k <= DEPTH; k++) pipe[k].v = 0;
    cnt_a = 0; cnt_b = 0;
    repeat (2) @(posedge clk);

    // ALU producer into EX consumer: no stall, forwarded from stage 2.
    step(0, 1, 0, 1, 3, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    step(0, 1, 0, 1, 6, 1, 3, 0, 2'b01, 2'b00, 0, -1, -1);
    nop(2);
    // Load-use on operand 1: one stall, then forwarded from stage 3.
    step(0, 1, 0, 1, 2, 2, 0, 0, 2'b00, 2'b00, 0, -1, -1);
    step(0, 1, 0, 1, 6, 1, 0, 2, 2'b10, 2'b00, 1, -1, -1);
    step(0, 1, 0, 1, 6, 1, 0, 2, 2'b10, 2'b00, 0, -1, -1);
    nop(3 << SW);
    // Early branch compare after ALU and after load.
    step(0, 1, 0, 1, 5, 1, 0, 0, 2'b00, 2'b00, 0, -1, -1);
    step(0, 1, 0, 0, 0, 1, 5, 0, 2'b01, 2'b01, 1, -1, -1);
    step(0, 1, 0, 0, 0, 1, 5, 0, 2'b01, 2'b01, 0, 2, -1);
    step(0, 1, 0, 1, 5, 2, 0, 0, 2'b00, 2'b00, 0, -1, -1);
    step(0, 1, 0, 0, 0, 1, 5, 0, 2'b01, 2'b01, 1, -1, -1);
    step(0, 1, 0, 0, 0, 1, 5, 0, 2'b01, 2'b01, 1, -1, -1);
    step(0, 1, 0, 0, 0, 1, 5, 0, 2'b01, 2'b01, 0, 3, -1);
    nop(-1); nop(-1); nop(-1); nop(-1);
    // Register 0 never hazards.
    step(0, 1, 0, 1, 0, 2, 0, 0, 2'b00, 2'b00, 0, -1, -1);
    step(0, 1, 0, 0, 0, 1, 0, 0, 2'b11, 2'b01, 0, 0, -1);
    nop(0);
    // Two writers of r4: youngest wins.
    step(0, 1, 0, 1, 4, 1, 0, 0, 2'b00, 2'b00, 0, -1, -1);
    step(0, 1, 0, 1, 4, 1, 0, 0, 2'b00, 2'b00, 0, -1, -1);
    nop(-1);
    step(0, 1, 0, 0, 0, 1, 4, 0, 2'b01, 2'b01, 0, 2, -1);
    // Producer in WB: RF bypass instance selects 0, the other selects 4.
    step(0, 1, 0, 1, 7, 1, 0, 0, 2'b00, 2'b00, 0, -1, -1);
    nop(-1); nop(-1); nop(-1);
    step(0, 1, 0, 0, 0, 1, 0, 7, 2'b10, 2'b10, 0, 0, -1);
    // Reset during a load-use stall, then kill during a stall condition.
    step(0, 1, 0, 1, 2, 2, 0, 0, 2'b00, 2'b00, 0, -1, -1);
    step(1, 1, 0, 1, 6, 1, 2, 0, 2'b01, 2'b00, 1, -1, -1);
    step(0, 1, 0, 1, 6, 1, 2, 0, 2'b01, 2'b00, 0, 0, 0);
    nop(-1); nop(-1); nop(-1); nop(-1);
    step(0, 1, 0, 1, 2, 2, 0, 0, 2'b00, 2'b00, 0, -1, -1);
    step(0, 1, 1, 1, 6, 1, 2, 0, 2'b01, 2'b00, 0, -1, -1);
    nop(0);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(1, 3),
           $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom), 2'($urandom), -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
